// File: rtl/shared_bus_lock_arbiter.sv
// shared_bus_lock_arbiter: round-robin arbiter for the shared global-memory/device bus.
// A requester can lock the grant to get atomic read-modify-write sequences.
// The grant is combinational so it reaches the request mux in the same cycle.
// Optional feature macro: ARB_LOCK_LIMIT_EN caps a lock tenure at MAX_LOCK consecutive grants.
module shared_bus_lock_arbiter #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  request,
  input  logic [NUM_REQ-1:0]  lock,
  output logic [NUM_REQ-1:0]  grant_oh,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                grant_valid,
  output logic                locked
);

  localparam int unsigned         CNT_W    = $clog2(MAX_LOCK + 1);
  localparam logic [ID_WIDTH-1:0] LAST_RST = ID_WIDTH'(NUM_REQ - 1);

  logic [ID_WIDTH-1:0] r_last_grant;
  logic                r_locked;
  logic [ID_WIDTH-1:0] r_owner;
  logic [CNT_W-1:0]    r_lock_cnt;

  logic                w_rr_found;
  logic [ID_WIDTH-1:0] w_rr_id;
  logic                w_lock_hit;
  logic                w_grant_valid;
  logic [ID_WIDTH-1:0] w_grant_id;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_locked_next;

  // Round-robin search: first requester after last_grant, wrapping, last_grant lowest priority
  always_comb begin
    int unsigned idx;
    w_rr_found = 1'b0;
    w_rr_id    = '0;
    idx        = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(r_last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_rr_found && request[ID_WIDTH'(idx)]) begin
        w_rr_found = 1'b1;
        w_rr_id    = ID_WIDTH'(idx);
      end
    end
  end

  // Final grant: a live lock tenure overrides round-robin; nothing granted during reset
  always_comb begin
    w_lock_hit    = r_locked && request[r_owner];
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    if (reset) begin
      w_grant_valid = 1'b0;
      w_grant_id    = '0;
    end else if (w_lock_hit) begin
      w_grant_valid = 1'b1;
      w_grant_id    = r_owner;
    end else if (w_rr_found) begin
      w_grant_valid = 1'b1;
      w_grant_id    = w_rr_id;
    end
  end

  // Tenure length and next lock state for the current grant
  always_comb begin
    w_cnt_next = (r_locked && (w_grant_id == r_owner)) ? (r_lock_cnt + CNT_W'(1)) : CNT_W'(1);
`ifdef ARB_LOCK_LIMIT_EN
    w_locked_next = lock[w_grant_id] && (w_cnt_next < CNT_W'(MAX_LOCK));
`else
    w_locked_next = lock[w_grant_id];
`endif
  end

  // Arbitration state update on every granted cycle; an idle cycle drops the lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= LAST_RST;
      r_locked     <= 1'b0;
      r_owner      <= '0;
      r_lock_cnt   <= '0;
    end else if (w_grant_valid) begin
      r_last_grant <= w_grant_id;
      r_locked     <= w_locked_next;
      r_owner      <= w_grant_id;
      r_lock_cnt   <= w_cnt_next;
    end else begin
      r_locked     <= 1'b0;
    end
  end

  assign grant_valid = w_grant_valid;
  assign grant_id    = w_grant_id;
  assign grant_oh    = w_grant_valid ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign locked      = r_locked;

endmodule

// File: tb/tb_shared_bus_lock_arbiter.sv
// Scoreboard bench for shared_bus_lock_arbiter: the driver queues the expected
// grant for each cycle it drives, a negedge monitor pops and compares.
module tb_shared_bus_lock_arbiter;

  localparam int unsigned NUM_REQ  = 8;
  localparam int unsigned ID_WIDTH = 3;
  localparam int unsigned MAX_LOCK = 4;

  typedef struct {
    logic                v;
    logic [ID_WIDTH-1:0] id;
    logic [NUM_REQ-1:0]  oh;
    logic                lk;
    string               name;
  } exp_t;

  logic                clk;
  logic                reset;
  logic [NUM_REQ-1:0]  request;
  logic [NUM_REQ-1:0]  lock;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_WIDTH-1:0] grant_id;
  logic                grant_valid;
  logic                locked;

  exp_t q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_err = 0;

  shared_bus_lock_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH),
    .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .request    (request),
    .lock       (lock),
    .grant_oh   (grant_oh),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // One cycle of stimulus plus its expected response
  task automatic step(input logic rst, input logic [NUM_REQ-1:0] req, input logic [NUM_REQ-1:0] lk_in,
                      input logic ev, input logic [ID_WIDTH-1:0] eid, input logic elk, input string nm);
    exp_t e;
    logic [NUM_REQ-1:0] one;
    @(posedge clk);
    #1;
    reset   = rst;
    request = req;
    lock    = lk_in;
    one     = 1;
    e.v     = ev;
    e.id    = ev ? eid : '0;
    e.oh    = ev ? (one << eid) : '0;
    e.lk    = elk;
    e.name  = nm;
    q.push_back(e);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation
  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      chk(me.name, "grant_valid", 32'(grant_valid), 32'(me.v));
      chk(me.name, "grant_id",    32'(grant_id),    32'(me.id));
      chk(me.name, "grant_oh",    32'(grant_oh),    32'(me.oh));
      chk(me.name, "locked",      32'(locked),      32'(me.lk));
    end
  end

  initial begin
    reset   = 1'b1;
    request = '0;
    lock    = '0;

    // Reset state with requests present
    step(1, 8'hFF, 8'h00, 0, 0, 0, "rst0");
    step(1, 8'hFF, 8'h00, 0, 0, 0, "rst1");

    // Full round-robin rotation
    for (int i = 0; i < 9; i++)
      step(0, 8'hFF, 8'h00, 1, ID_WIDTH'(i % 8), 0, $sformatf("rr%0d", i));

    // Wrap: last_grant=2, requesters 2 and 5
    step(0, 8'h04, 8'h00, 1, 2, 0, "set_last2");
    step(0, 8'h24, 8'h00, 1, 5, 0, "wrap_a");
    step(0, 8'h24, 8'h00, 1, 2, 0, "wrap_b");

    // Requester 3 locks for 6 cycles, then drops lock
`ifdef ARB_LOCK_LIMIT_EN
    step(0, 8'hFF, 8'h08, 1, 3, 0, "lim1");
    step(0, 8'hFF, 8'h08, 1, 3, 1, "lim2");
    step(0, 8'hFF, 8'h08, 1, 3, 1, "lim3");
    step(0, 8'hFF, 8'h08, 1, 3, 1, "lim4");
    step(0, 8'hFF, 8'h08, 1, 4, 0, "lim5");
    step(0, 8'hFF, 8'h08, 1, 5, 0, "lim6");
    step(0, 8'hFF, 8'h00, 1, 6, 0, "lim7");
    step(0, 8'hFF, 8'h00, 1, 7, 0, "lim8");
`else
    step(0, 8'hFF, 8'h08, 1, 3, 0, "lk1");
    step(0, 8'hFF, 8'h08, 1, 3, 1, "lk2");
    step(0, 8'hFF, 8'h08, 1, 3, 1, "lk3");
    step(0, 8'hFF, 8'h08, 1, 3, 1, "lk4");
    step(0, 8'hFF, 8'h08, 1, 3, 1, "lk5");
    step(0, 8'hFF, 8'h08, 1, 3, 1, "lk6");
    step(0, 8'hFF, 8'h00, 1, 3, 1, "lk7");
    step(0, 8'hFF, 8'h00, 1, 4, 0, "lk8");
`endif
    step(0, 8'h80, 8'h00, 1, 7, 0, "norm7");

    // Owner drops request while locked: immediate handover
    step(0, 8'h08, 8'h08, 1, 3, 0, "ho_a");
    step(0, 8'h08, 8'h08, 1, 3, 1, "ho_b");
    step(0, 8'h01, 8'h01, 1, 0, 1, "ho_c");
    step(0, 8'h01, 8'h00, 1, 0, 1, "ho_d");
    step(0, 8'h01, 8'h00, 1, 0, 0, "ho_e");
    step(0, 8'h08, 8'h08, 1, 3, 0, "ho_f");
    step(0, 8'h08, 8'h08, 1, 3, 1, "ho_g");
    step(0, 8'h01, 8'h00, 1, 0, 1, "ho_h");
    step(0, 8'hFF, 8'h00, 1, 1, 0, "ho_i");

    // Lock without a grant has no effect; idle cycle
    step(0, 8'h02, 8'h04, 1, 1, 0, "nolk_a");
    step(0, 8'h04, 8'h00, 1, 2, 0, "nolk_b");
    step(0, 8'h00, 8'hFF, 0, 0, 0, "idle");
    step(0, 8'hFF, 8'h00, 1, 3, 0, "after_idle");

    // Reset mid-tenure with owner 5
    step(0, 8'h20, 8'h20, 1, 5, 0, "mt_a");
    step(0, 8'hFF, 8'h20, 1, 5, 1, "mt_b");
    step(1, 8'hFF, 8'h20, 0, 0, 0, "mt_rst0");
    step(1, 8'hFF, 8'h20, 0, 0, 0, "mt_rst1");
    step(0, 8'hFF, 8'h00, 1, 0, 0, "mt_rel");
    step(0, 8'hFF, 8'h00, 1, 1, 0, "mt_next");

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
